// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Purpose  : Controller for the BCD twelve-hour clock datapath. Generates the
//            1 Hz count-enable and runs a button-driven set-time FSM that
//            edits shadow hour/minute/AM-PM registers and commits them to the
//            clock with a one-cycle parallel load.
// Optional : define SET_TIMEOUT_EN to abort an idle edit after TIMEOUT_CYC
//            cycles (no load issued).
// Ports    : clk, reset (sync, active-high)
//            btn_mode, btn_inc      debounced button levels
//            cur_pm, cur_hh, cur_mm current clock time (BCD)
//            clk_ena                one-cycle count enable to the clock
//            load, load_pm/hh/mm/ss parallel-load strobe and data
//            edit_sel               0 run, 1 hours, 2 minutes, 3 commit
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       cur_pm,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    output logic       clk_ena,
    output logic       load,
    output logic       load_pm,
    output logic [7:0] load_hh,
    output logic [7:0] load_mm,
    output logic [7:0] load_ss,
    output logic [1:0] edit_sel
);

    localparam int             PRE_W     = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SET_HH = 2'd1,
        S_SET_MM = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [PRE_W-1:0]   pre_cnt;
    logic               mode_prev, inc_prev;
    logic               mode_evt, inc_evt;
    logic [7:0]         sh_hh, sh_mm;
    logic               sh_pm;
    logic [7:0]         hh_inc, mm_inc, hh_cap, mm_cap;
    logic               timeout_hit;

    // Button history resets to 1 so a button held through reset must be
    // released and pressed again before it produces an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            mode_evt  <= 1'b0;
            inc_evt   <= 1'b0;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            mode_evt  <= btn_mode & ~mode_prev;
            inc_evt   <= btn_inc & ~inc_prev;
        end
    end

    // Prescaler only counts in RUN; held at 0 elsewhere so the first enable
    // after an edit comes a full TICK_DIV cycles later.
    always_ff @(posedge clk) begin
        if (reset || state != S_RUN || pre_cnt == TICK_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign clk_ena = (state == S_RUN) && (pre_cnt == TICK_LAST);

`ifdef SET_TIMEOUT_EN
    localparam int              IDLE_W  = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              in_set;

    assign in_set = (state == S_SET_HH) || (state == S_SET_MM);

    // Cleared on any state change (covers entry to each set state) and on
    // every button event; counts only while editing.
    always_ff @(posedge clk) begin
        if (reset || !in_set || state_next != state || mode_evt || inc_evt)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout_hit = in_set && (idle_cnt == TO_LAST);
`else
    // Feature not built: the comparison is constant false for any legal
    // TIMEOUT_CYC, so set states persist indefinitely.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_next;
    end

    // Mode has priority over inc and over an idle timeout on the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_RUN:    if (mode_evt) state_next = S_SET_HH;
            S_SET_HH: if (mode_evt) state_next = S_SET_MM;
                      else if (timeout_hit) state_next = S_RUN;
            S_SET_MM: if (mode_evt) state_next = S_COMMIT;
                      else if (timeout_hit) state_next = S_RUN;
            S_COMMIT: state_next = S_RUN;
            default:  state_next = S_RUN;
        endcase
    end

    // Capture sanitisation and BCD increment values.
    always_comb begin
        hh_cap = 8'h12;
        mm_cap = 8'h00;
        if ((cur_hh[7:4] == 4'd0 && cur_hh[3:0] >= 4'd1 && cur_hh[3:0] <= 4'd9) ||
            (cur_hh[7:4] == 4'd1 && cur_hh[3:0] <= 4'd2))
            hh_cap = cur_hh;
        if (cur_mm[7:4] <= 4'd5 && cur_mm[3:0] <= 4'd9)
            mm_cap = cur_mm;

        if (sh_hh == 8'h12)
            hh_inc = 8'h01;
        else if (sh_hh[3:0] == 4'd9)
            hh_inc = 8'h10;
        else
            hh_inc = {sh_hh[7:4], sh_hh[3:0] + 4'd1};

        if (sh_mm == 8'h59)
            mm_inc = 8'h00;
        else if (sh_mm[3:0] == 4'd9)
            mm_inc = {sh_mm[7:4] + 4'd1, 4'd0};
        else
            mm_inc = {sh_mm[7:4], sh_mm[3:0] + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_hh <= 8'h12;
            sh_mm <= 8'h00;
            sh_pm <= 1'b0;
        end else begin
            case (state)
                S_RUN: if (mode_evt) begin
                    sh_hh <= hh_cap;
                    sh_mm <= mm_cap;
                    sh_pm <= cur_pm;
                end
                S_SET_HH: if (!mode_evt && inc_evt) begin
                    sh_hh <= hh_inc;
                    // Only the 11 -> 12 step crosses noon/midnight.
                    if (sh_hh == 8'h11) sh_pm <= ~sh_pm;
                end
                S_SET_MM: if (!mode_evt && inc_evt) sh_mm <= mm_inc;
                default: ;
            endcase
        end
    end

    assign load     = (state == S_COMMIT);
    assign load_hh  = sh_hh;
    assign load_mm  = sh_mm;
    assign load_pm  = sh_pm;
    assign load_ss  = 8'h00;
    assign edit_sel = state;

endmodule
`default_nettype wire
